// File: rtl/cpu_defs_pkg.sv
// cpu_defs_pkg: shared access-size, error and LSU state encodings for the CPU core
package cpu_defs_pkg;
  localparam logic [1:0] SIZE_B = 2'b00, SIZE_H = 2'b01, SIZE_W = 2'b10, SIZE_D = 2'b11;
  localparam logic [1:0] ERR_OK = 2'b00, ERR_MISAL = 2'b01, ERR_TIMEOUT = 2'b10;
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} lsu_state_e;
  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a, input int data_w);
    return (size == SIZE_D && data_w == 32) || |(a & 3'((4'd1 << size) - 4'd1));
  endfunction
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: little-endian lane extract/extend for loads and lane merge for sub-word stores
module lsu_lane_align
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = DATA_W / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [1:0]        size_i,
  input  logic              sgn_i,
  input  logic [OW-1:0]     off_i,
  input  logic [DATA_W-1:0] rword_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] ld_o,
  output logic [DATA_W-1:0] mg_o
);
  logic [DATA_W-1:0] sh, ws, m;
  logic [NB-1:0] bm;
  assign sh = rword_i >> {off_i, 3'b000};
  assign ws = wdata_i << {off_i, 3'b000};
  assign bm = NB'((32'd1 << (32'd1 << size_i)) - 32'd1) << off_i;
  for (genvar i = 0; i < NB; i++) begin : g_lane
    assign m[8*i +: 8] = {8{bm[i]}};
  end
  always_comb begin
    ld_o = size_i == SIZE_B ? (sgn_i ? DATA_W'($signed(sh[7:0]))  : DATA_W'(sh[7:0]))  :
           size_i == SIZE_H ? (sgn_i ? DATA_W'($signed(sh[15:0])) : DATA_W'(sh[15:0])) :
           size_i == SIZE_W ? (sgn_i ? DATA_W'($signed(sh[31:0])) : DATA_W'(sh[31:0])) : sh;
    mg_o = (rword_i & ~m) | (ws & m);
  end
endmodule

// File: rtl/lsu_mem_path.sv
// lsu_mem_path: load/store unit between datapath and MIO bus with RMW sub-word stores.
// Define LSU_TIMEOUT_EN to abort accesses after TO_CYC cycles without MIO_ready.
module lsu_mem_path
  import cpu_defs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TO_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [1:0]        resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] M_addr,
  output logic [DATA_W-1:0] data_out,
  input  logic              MIO_ready,
  input  logic [DATA_W-1:0] data2CPU
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  lsu_state_e state_q, state_d;
  logic we_q, sgn_q, accept, bad, full, busy, to_hit;
  logic [1:0] size_q, err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q, data_out_q, rdata_q, ld_data, mg_data;
  assign accept = state_q == S_IDLE && req_valid;
  assign bad = misaligned(req_size, req_addr[2:0], DATA_W);
  assign full = req_size == (DATA_W == 64 ? SIZE_D : SIZE_W);
  assign busy = state_q == S_RD || state_q == S_WR;
`ifdef LSU_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYC + 1);
  logic [CW-1:0] cnt_q;
  assign to_hit = busy && !MIO_ready && cnt_q == CW'(TO_CYC - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (state_d != state_q && (state_d == S_RD || state_d == S_WR)) cnt_q <= '0;
    else if (busy && !MIO_ready) cnt_q <= cnt_q + 1'b1;
`else
  assign to_hit = 1'b0;
`endif
  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .size_i (size_q),
    .sgn_i  (sgn_q),
    .off_i  (addr_q[OW-1:0]),
    .rword_i(data2CPU),
    .wdata_i(wdata_q),
    .ld_o   (ld_data),
    .mg_o   (mg_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= S_IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = bad ? S_RESP : (req_we && full) ? S_WR : S_RD;
      S_RD:    if (MIO_ready) state_d = we_q ? S_WR : S_RESP;
               else if (to_hit) state_d = S_RESP;
      S_WR:    if (MIO_ready || to_hit) state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    req_ready  = state_q == S_IDLE;
    resp_valid = state_q == S_RESP;
    mem_req    = busy;
    mem_we     = state_q == S_WR;
    M_addr     = {addr_q[ADDR_W-1:OW], OW'(0)};
    data_out   = data_out_q;
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end
  // rdata is cleared at accept so stores and errors respond with zero
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      we_q       <= 1'b0;
      sgn_q      <= 1'b0;
      size_q     <= SIZE_B;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_out_q <= '0;
      rdata_q    <= '0;
      err_q      <= ERR_OK;
    end else if (accept) begin
      we_q       <= req_we;
      sgn_q      <= req_signed;
      size_q     <= req_size;
      addr_q     <= req_addr;
      wdata_q    <= req_wdata;
      data_out_q <= req_wdata;
      rdata_q    <= '0;
      err_q      <= bad ? ERR_MISAL : ERR_OK;
    end else if (state_q == S_RD && MIO_ready) begin
      if (we_q) data_out_q <= mg_data;
      else rdata_q <= ld_data;
    end else if (to_hit) err_q <= ERR_TIMEOUT;
endmodule

// File: tb/tb_lsu_mem_path.sv
// tb_lsu_mem_path: randomized self-checking bench for lsu_mem_path against a byte-level reference model
module tb_lsu_mem_path;
  localparam int DW = 32, AW = 32;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_ready, req_we = 0, req_signed = 0;
  logic [1:0] req_size = 0;
  logic [AW-1:0] req_addr = 0;
  logic [DW-1:0] req_wdata = 0;
  logic resp_valid, mem_req, mem_we, MIO_ready = 0;
  logic [DW-1:0] resp_rdata, data_out, data2CPU = 0;
  logic [1:0] resp_err;
  logic [AW-1:0] M_addr;
  int checks = 0, errors = 0;
  int o_lat, o_req_hi, o_we_hi;
  logic [31:0] o_rdata, o_wdata, o_waddr, o_raddr;
  logic [1:0] o_err;
  logic o_rd, o_wr, o_pulse2, o_ready2, o_acc_ready;

  always #5 clk = ~clk;

  lsu_mem_path #(.DATA_W(DW), .ADDR_W(AW), .TO_CYC(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req),
    .mem_we(mem_we), .M_addr(M_addr), .data_out(data_out), .MIO_ready(MIO_ready), .data2CPU(data2CPU)
  );

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [31:0] a, input int n, input logic sgn);
    logic [31:0] v = 0;
    int off = int'(a[1:0]);
    for (int i = 0; i < n; i++) v |= ((w >> (8 * (off + i))) & 32'hFF) << (8 * i);
    if (sgn && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] a, input int n, input logic [31:0] wd);
    logic [7:0] b[4];
    int off = int'(a[1:0]);
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    for (int i = 0; i < n; i++) b[off+i] = wd[8*i +: 8];
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Issues one request and plays the bus: each beat waits `waits` cycles before MIO_ready.
  task automatic do_access(input logic we, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] old, input int waits);
    int w = 0;
    o_lat = -1; o_req_hi = 0; o_we_hi = 0; o_rd = 0; o_wr = 0;
    o_rdata = 'x; o_err = 'x; o_wdata = 'x; o_waddr = 'x; o_raddr = 'x;
    @(negedge clk);
    o_acc_ready = req_ready;
    req_valid = 1; req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
    MIO_ready = 0;
    @(negedge clk);
    req_valid = 0; req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 300; c++) begin
      if (resp_valid) begin
        o_lat = c; o_rdata = resp_rdata; o_err = resp_err;
        break;
      end
      if (mem_req) begin
        o_req_hi++;
        if (mem_we) o_we_hi++;
        if (w < waits) begin
          w++; MIO_ready = 0; data2CPU = $urandom;
        end else begin
          w = 0; MIO_ready = 1;
          if (mem_we) begin o_wr = 1; o_wdata = data_out; o_waddr = M_addr; end
          else begin o_rd = 1; o_raddr = M_addr; data2CPU = old; end
        end
      end else begin
        MIO_ready = 1'($urandom); data2CPU = $urandom;
      end
      @(negedge clk);
    end
    MIO_ready = 0;
    @(negedge clk);
    o_pulse2 = resp_valid; o_ready2 = req_ready;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, mem_req, mem_we} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl: got %b required 1000", {req_ready, resp_valid, mem_req, mem_we});
    end
    checks++;
    if ({M_addr, data_out, resp_rdata, resp_err} !== '0) begin
      errors++; $display("FAIL reset_data: addr %h dout %h rdata %h err %b required all 0", M_addr, data_out, resp_rdata, resp_err);
    end
  endtask

  task automatic test_load_byte;
    do_access(0, 2'b00, 1, 32'h1003, 0, 32'h80FF_1234, 0);
    checks++;
    if (o_rdata !== 32'hFFFF_FF80 || o_err !== 2'b00) begin
      errors++; $display("FAIL lb_data: rdata %h err %b required ffffff80 00", o_rdata, o_err);
    end
    checks++;
    if (o_lat !== 2 || o_raddr !== 32'h1000 || o_wr !== 0) begin
      errors++; $display("FAIL lb_timing: lat %0d raddr %h wr %b required 2 00001000 0", o_lat, o_raddr, o_wr);
    end
  endtask

  task automatic test_store_half;
    do_access(1, 2'b01, 0, 32'h2002, 32'h0000_BEEF, 32'h1122_3344, 0);
    checks++;
    if (o_rd !== 1 || o_wr !== 1 || o_wdata !== 32'hBEEF_3344 || o_waddr !== 32'h2000) begin
      errors++; $display("FAIL sh_merge: rd %b wr %b data %h addr %h required 1 1 beef3344 00002000", o_rd, o_wr, o_wdata, o_waddr);
    end
    checks++;
    if (o_lat !== 3 || o_err !== 2'b00 || o_rdata !== 0) begin
      errors++; $display("FAIL sh_resp: lat %0d err %b rdata %h required 3 00 0", o_lat, o_err, o_rdata);
    end
  endtask

  task automatic test_misaligned;
    do_access(0, 2'b10, 0, 32'h0006, 0, 32'hDEAD_BEEF, 0);
    checks++;
    if (o_lat !== 1 || o_err !== 2'b01 || o_req_hi !== 0 || o_rdata !== 0) begin
      errors++; $display("FAIL lw_misal: lat %0d err %b req_cycles %0d rdata %h required 1 01 0 0", o_lat, o_err, o_req_hi, o_rdata);
    end
  endtask

  task automatic test_wait_store;
    do_access(1, 2'b10, 0, 32'h0000_0340, 32'hCAFE_F00D, 32'h0, 5);
    checks++;
    if (o_req_hi !== 6 || o_we_hi !== 6 || o_rd !== 0) begin
      errors++; $display("FAIL sw_wait_bus: req %0d we %0d rd %b required 6 6 0", o_req_hi, o_we_hi, o_rd);
    end
    checks++;
    if (o_lat !== 7 || o_wdata !== 32'hCAFE_F00D || o_pulse2 !== 0 || o_ready2 !== 1) begin
      errors++; $display("FAIL sw_wait_resp: lat %0d data %h pulse2 %b ready %b required 7 cafef00d 0 1", o_lat, o_wdata, o_pulse2, o_ready2);
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    do_access(1, 2'b01, 0, 32'h0010, 32'h1234, 32'h5555_5555, 1000);
    checks++;
    if (o_lat !== 9 || o_err !== 2'b10 || o_rdata !== 0 || o_wr !== 0 || o_req_hi !== 8) begin
      errors++; $display("FAIL timeout: lat %0d err %b rdata %h wr %b req %0d required 9 10 0 0 8", o_lat, o_err, o_rdata, o_wr, o_req_hi);
    end
  endtask
`endif

  task automatic test_reset_mid;
    logic seen = 0;
    @(negedge clk);
    req_valid = 1; req_we = 1; req_size = 2'b10; req_addr = 32'h80; req_wdata = 32'h0BAD_0BAD; MIO_ready = 0;
    @(negedge clk);
    req_valid = 0;
    checks++;
    if (mem_we !== 1 || mem_req !== 1) begin
      errors++; $display("FAIL rst_mid_pre: mem_req %b mem_we %b required 1 1", mem_req, mem_we);
    end
    @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (mem_we !== 0 || mem_req !== 0) begin
      errors++; $display("FAIL rst_mid_drop: mem_req %b mem_we %b required 0 0", mem_req, mem_we);
    end
    @(negedge clk);
    rst = 0; MIO_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen |= resp_valid;
    end
    MIO_ready = 0;
    checks++;
    if (seen !== 0 || req_ready !== 1) begin
      errors++; $display("FAIL rst_mid_after: resp_seen %b req_ready %b required 0 1", seen, req_ready);
    end
  endtask

  task automatic test_random;
    logic we, sgn, bad;
    logic [1:0] sz;
    logic [31:0] a, wd, old, er, ew;
    int n, waits, el;
    for (int t = 0; t < 80; t++) begin
      sz = ($urandom % 8 == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a = $urandom;
      if ($urandom % 4 != 0) a &= ~((32'd1 << sz) - 1);
      we = 1'($urandom); sgn = 1'($urandom); wd = $urandom; old = $urandom;
      waits = $urandom_range(0, 3);
      do_access(we, sz, sgn, a, wd, old, waits);
      n = 1 << sz;
      bad = sz == 2'b11 || (a % n) != 0;
      el = bad ? 1 : (!we || n == 4) ? 2 + waits : 3 + 2 * waits;
      er = (bad || we) ? 0 : ref_load(old, a, n, sgn);
      ew = n == 4 ? wd : ref_store(old, a, n, wd);
      checks++;
      if (o_acc_ready !== 1 || o_lat !== el || o_err !== (bad ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL rand%0d_resp: ready %b lat %0d err %b required 1 %0d %b", t, o_acc_ready, o_lat, o_err, el, bad ? 2'b01 : 2'b00);
      end
      checks++;
      if (o_rdata !== er || o_pulse2 !== 0) begin
        errors++; $display("FAIL rand%0d_rdata: rdata %h pulse2 %b required %h 0", t, o_rdata, o_pulse2, er);
      end
      checks++;
      if (o_wr !== (!bad && we) || o_rd !== (!bad && !(we && n == 4))) begin
        errors++; $display("FAIL rand%0d_beats: wr %b rd %b required %b %b", t, o_wr, o_rd, !bad && we, !bad && !(we && n == 4));
      end
      if (!bad && we) begin
        checks++;
        if (o_wdata !== ew || o_waddr !== {a[31:2], 2'b00}) begin
          errors++; $display("FAIL rand%0d_wdata: data %h addr %h required %h %h", t, o_wdata, o_waddr, ew, {a[31:2], 2'b00});
        end
      end
    end
  endtask

  initial begin
    #12 rst = 0;
    test_reset;
    test_load_byte;
    test_store_half;
    test_misaligned;
    test_wait_store;
`ifdef LSU_TIMEOUT_EN
    test_timeout;
`endif
    test_reset_mid;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
